// File: rtl/serial_frame_loader.sv
// Serial-to-parallel frame loader: MSB-first pixel stream into a double-buffered signed output bus.
// Optional even-parity trailer bit enabled by defining SERIAL_FRAME_LOADER_PARITY_EN.
module serial_frame_loader #(
   parameter int numInputs     = 784,
   parameter int bitsPerPixel  = 4,
   parameter int dataWidth     = 16,
   parameter int dataFracWidth = 8,
   parameter int pixelShift    = 9
) (
   input  logic                           serialClock,
   input  logic                           reset,
   input  logic                           serialData,
   input  logic                           serialValid,
   input  logic                           frameStart,
   input  logic                           frameAck,
   input  logic                           clearErrors,
   output logic [numInputs*dataWidth-1:0] dataOut,
   output logic                           frameValid,
   output logic                           busy,
   output logic                           overrunError,
   output logic                           framingError,
   output logic                           parityError
);

   localparam int FRAME_BITS = numInputs * bitsPerPixel;
   localparam int BW         = $clog2(bitsPerPixel + 1);
   localparam int PW         = $clog2(numInputs + 1);

   if (bitsPerPixel < 1 || bitsPerPixel + pixelShift > dataWidth - 1 ||
       dataFracWidth > dataWidth) begin : g_bad_params
      $error("serial_frame_loader: pixel does not fit the signed output word");
   end

`ifdef SERIAL_FRAME_LOADER_PARITY_EN
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PARITY} state_t;
   localparam state_t ST_DONE = ST_PARITY;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD} state_t;
   localparam state_t ST_DONE = ST_IDLE;
`endif

   state_t                          r_state, w_state_next;
   logic [BW-1:0]                   r_bit_cnt;
   logic [PW-1:0]                   r_pix_cnt;
   logic [FRAME_BITS-1:0]           r_shadow;
   logic [numInputs*dataWidth-1:0]  r_data_out;
   logic                            r_frame_valid, r_busy;
   logic                            r_overrun, r_framing;

   logic [BW-1:0]                   w_cur_bit;
   logic [PW-1:0]                   w_cur_pix;
   logic                            w_bit_wrap, w_last, w_data_beat, w_framing_evt;
   logic                            w_commit_req, w_commit, w_overrun_evt;
   logic [FRAME_BITS-1:0]           w_shadow_base, w_shadow_next, w_pix_src;
   logic [numInputs*dataWidth-1:0]  w_expanded;

   // A frameStart beat restarts from bit 0 regardless of what was loaded so far.
   assign w_cur_bit     = frameStart ? '0 : r_bit_cnt;
   assign w_cur_pix     = frameStart ? '0 : r_pix_cnt;
   assign w_bit_wrap    = (w_cur_bit == BW'(bitsPerPixel - 1));
   assign w_last        = w_bit_wrap && (w_cur_pix == PW'(numInputs - 1));
   assign w_shadow_base = frameStart ? '0 : r_shadow;
   assign w_shadow_next = (w_shadow_base << 1) | FRAME_BITS'(serialData);
   assign w_framing_evt = serialValid && frameStart && (r_state != ST_IDLE);

`ifdef SERIAL_FRAME_LOADER_PARITY_EN
   logic r_parity_err, w_par_beat, w_par_ok;
   assign w_data_beat  = serialValid && (frameStart || r_state == ST_LOAD);
   assign w_par_beat   = serialValid && !frameStart && (r_state == ST_PARITY);
   assign w_par_ok     = ~(^r_shadow ^ serialData);
   assign w_commit_req = w_par_beat && w_par_ok;
   assign w_pix_src    = r_shadow;
   assign parityError  = r_parity_err;
`else
   assign w_data_beat  = serialValid && (frameStart || r_state != ST_IDLE);
   assign w_commit_req = w_data_beat && w_last;
   assign w_pix_src    = w_shadow_next;
   assign parityError  = 1'b0;
`endif

   assign w_commit      = w_commit_req && (!r_frame_valid || frameAck);
   assign w_overrun_evt = w_commit_req && !w_commit;

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      w_expanded = '0;
      for (int i = 0; i < numInputs; i++) begin
         w_expanded[dataWidth*i +: dataWidth] =
            {{(dataWidth - bitsPerPixel){1'b0}}, w_pix_src[bitsPerPixel*i +: bitsPerPixel]} << pixelShift;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (w_data_beat) w_state_next = w_last ? ST_DONE : ST_LOAD;
`ifdef SERIAL_FRAME_LOADER_PARITY_EN
      if (w_par_beat) w_state_next = ST_IDLE;
`endif
   end

   always_ff @(posedge serialClock or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge serialClock or posedge reset) begin
      if (reset) begin
         // NOTE: the shadow is reset as well, so a restart never exposes stale frame bits.
         r_bit_cnt     <= '0;
         r_pix_cnt     <= '0;
         r_shadow      <= '0;
         r_data_out    <= '0;
         r_frame_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_overrun     <= 1'b0;
         r_framing     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         if (w_data_beat) begin
            r_shadow <= w_shadow_next;
            if (w_last) begin
               r_bit_cnt <= '0;
               r_pix_cnt <= '0;
            end else if (w_bit_wrap) begin
               r_bit_cnt <= '0;
               r_pix_cnt <= w_cur_pix + PW'(1);
            end else begin
               r_bit_cnt <= w_cur_bit + BW'(1);
               r_pix_cnt <= w_cur_pix;
            end
         end
         if (w_commit) begin
            r_data_out    <= w_expanded;
            r_frame_valid <= 1'b1;
         end else if (frameAck) begin
            r_frame_valid <= 1'b0;
         end
         r_busy    <= (w_state_next != ST_IDLE);
         r_overrun <= w_overrun_evt || (r_overrun && !clearErrors);
         r_framing <= w_framing_evt || (r_framing && !clearErrors);
      end
   end

`ifdef SERIAL_FRAME_LOADER_PARITY_EN
   always_ff @(posedge serialClock or posedge reset) begin
      if (reset) r_parity_err <= 1'b0;
      else       r_parity_err <= (w_par_beat && !w_par_ok) || (r_parity_err && !clearErrors);
   end
`endif

   assign dataOut      = r_data_out;
   assign frameValid   = r_frame_valid;
   assign busy         = r_busy;
   assign overrunError = r_overrun;
   assign framingError = r_framing;

endmodule

// File: tb/tb_serial_frame_loader.sv
// Directed, scoreboard-based bench for serial_frame_loader (4 pixels x 2 bits, shift 4, 8-bit words).
// Also exercises the parity trailer when SERIAL_FRAME_LOADER_PARITY_EN is defined.
module tb_serial_frame_loader;

   localparam int N   = 4;
   localparam int BPP = 2;
   localparam int DW  = 8;
   localparam int PS  = 4;

   logic          serialClock = 1'b0;
   logic          reset, serialData, serialValid, frameStart, frameAck, clearErrors;
   logic [N*DW-1:0] dataOut;
   logic          frameValid, busy, overrunError, framingError, parityError;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [31:0]   exp_q[$];

   serial_frame_loader #(
      .numInputs(N), .bitsPerPixel(BPP), .dataWidth(DW), .dataFracWidth(4), .pixelShift(PS)
   ) dut (
      .serialClock (serialClock),
      .reset       (reset),
      .serialData  (serialData),
      .serialValid (serialValid),
      .frameStart  (frameStart),
      .frameAck    (frameAck),
      .clearErrors (clearErrors),
      .dataOut     (dataOut),
      .frameValid  (frameValid),
      .busy        (busy),
      .overrunError(overrunError),
      .framingError(framingError),
      .parityError (parityError)
   );

   always #5 serialClock = ~serialClock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   // First streamed pixel is the top word; each pixel lands at bits [PS +: BPP] of its word.
   function automatic logic [31:0] model(input logic [7:0] s);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[DW*i +: DW] = {2'b00, s[BPP*i +: BPP], 4'b0000};
      return r;
   endfunction

   task automatic tick();
      @(negedge serialClock);
   endtask

   task automatic send_bit(input logic d, input logic st, input logic ack, input logic clr);
      serialData  = d;
      serialValid = 1'b1;
      frameStart  = st;
      frameAck    = ack;
      clearErrors = clr;
      tick();
      serialData  = 1'b0;
      serialValid = 1'b0;
      frameStart  = 1'b0;
      frameAck    = 1'b0;
      clearErrors = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] s, input int first, input int count, input int gap);
      for (int i = first; i < first + count; i++) begin
         send_bit(s[7-i], (i == 0), 1'b0, 1'b0);
         repeat (gap) tick();
      end
   endtask

   // Final beat of a frame: the last data bit, or the parity bit when the trailer is enabled.
   task automatic send_tail(input logic [7:0] s, input logic ack, input logic clr);
`ifdef SERIAL_FRAME_LOADER_PARITY_EN
      send_bit(s[0], 1'b0, 1'b0, 1'b0);
      send_bit(^s, 1'b0, ack, clr);
`else
      send_bit(s[0], 1'b0, ack, clr);
`endif
   endtask

   task automatic send_frame(input logic [7:0] s, input logic ack, input logic clr);
      send_bits(s, 0, 7, 0);
      send_tail(s, ack, clr);
   endtask

   task automatic do_ack();
      frameAck = 1'b1;
      tick();
      frameAck = 1'b0;
   endtask

   task automatic expect_commit(input string tag);
      check({tag, "_valid"}, 32'(frameValid), 32'd1);
      check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) check({tag, "_data"}, dataOut, exp_q.pop_front());
   endtask

   initial begin
      reset = 1'b1; serialData = 1'b0; serialValid = 1'b0;
      frameStart = 1'b0; frameAck = 1'b0; clearErrors = 1'b0;
      tick(); tick();
      check("rst_data", dataOut, 32'h0);
      check("rst_flags", {27'd0, frameValid, busy, overrunError, framingError, parityError}, 32'h0);
      reset = 1'b0;
      tick();

      // Contiguous frame 11 01 00 10
      exp_q.push_back(model(8'hD2));
      send_bit(1'b1, 1'b1, 1'b0, 1'b0);
      check("t1_busy_first", 32'(busy), 32'd1);
      send_bits(8'hD2, 1, 6, 0);
      check("t1_no_valid_early", 32'(frameValid), 32'd0);
      send_tail(8'hD2, 1'b0, 1'b0);
      expect_commit("t1");
      check("t1_busy_fall", 32'(busy), 32'd0);
      tick(); tick();
      check("t1_hold", dataOut, model(8'hD2));
      do_ack();
      check("t1_ack", 32'(frameValid), 32'd0);
      do_ack();
      check("t1_ack_idle", 32'(frameValid), 32'd0);

      // Same frame with three idle cycles between bits
      exp_q.push_back(model(8'hD2));
      send_bits(8'hD2, 0, 4, 3);
      check("t2_gap_busy", 32'(busy), 32'd1);
      check("t2_gap_valid", 32'(frameValid), 32'd0);
      send_bits(8'hD2, 4, 3, 3);
      send_tail(8'hD2, 1'b0, 1'b0);
      expect_commit("t2");
      do_ack();

      // Overrun, then a commit racing the ack
      exp_q.push_back(model(8'h1B));
      send_frame(8'h1B, 1'b0, 1'b0);
      expect_commit("t3_a");
      send_frame(8'hE4, 1'b0, 1'b0);
      check("t3_overrun", 32'(overrunError), 32'd1);
      check("t3_keep_a", dataOut, model(8'h1B));
      check("t3_keep_valid", 32'(frameValid), 32'd1);
      exp_q.push_back(model(8'h9C));
      send_frame(8'h9C, 1'b1, 1'b0);
      expect_commit("t3_c");
      do_ack();
      check("t3_ack", 32'(frameValid), 32'd0);
      clearErrors = 1'b1; tick(); clearErrors = 1'b0;
      check("t3_clear", 32'(overrunError), 32'd0);

      // Restart mid-frame
      send_bits(8'hFF, 0, 5, 0);
      check("t4_no_err_yet", 32'(framingError), 32'd0);
      exp_q.push_back(model(8'h5A));
      send_frame(8'h5A, 1'b0, 1'b0);
      check("t4_framing", 32'(framingError), 32'd1);
      expect_commit("t4");
      clearErrors = 1'b1; tick(); clearErrors = 1'b0;
      check("t4_clear", 32'(framingError), 32'd0);
      send_frame(8'h33, 1'b0, 1'b1);
      check("t4_event_beats_clear", 32'(overrunError), 32'd1);
      check("t4_keep", dataOut, model(8'h5A));

      // Asynchronous reset mid-load
      send_bits(8'hFF, 0, 6, 0);
      check("t5_busy", 32'(busy), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("t5_rst_data", dataOut, 32'h0);
      check("t5_rst_flags", {27'd0, frameValid, busy, overrunError, framingError, parityError}, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      exp_q.push_back(model(8'h2D));
      send_frame(8'h2D, 1'b0, 1'b0);
      expect_commit("t5");
      check("t5_no_framing", 32'(framingError), 32'd0);

`ifdef SERIAL_FRAME_LOADER_PARITY_EN
      do_ack();
      exp_q.push_back(model(8'hD2));
      send_bits(8'hD2, 0, 8, 0);
      check("par_wait_busy", 32'(busy), 32'd1);
      check("par_wait_valid", 32'(frameValid), 32'd0);
      send_bit(1'b0, 1'b0, 1'b0, 1'b0);
      expect_commit("par_ok");
      do_ack();
      send_bits(8'hD2, 0, 8, 0);
      send_bit(1'b1, 1'b0, 1'b0, 1'b0);
      check("par_err", 32'(parityError), 32'd1);
      check("par_no_commit", 32'(frameValid), 32'd0);
      check("par_keep", dataOut, model(8'hD2));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed no end, expected summary");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serial_frame_loader.md
Name: serial_frame_loader

Overview:
- Parametrised successor to the 1-bit input shift register.
- Receives a serial bitstream of multi-bit unsigned pixels, MSB first, qualified by a valid strobe and framed by a start pulse.
- Assembles a full frame in a shadow register, then commits it to a double-buffered, signed fixed-point output bus.
- The committed frame is offered to the first network layer through a valid/ack handshake.

Parameters:
- numInputs, 784, pixels per frame.
- bitsPerPixel, 4, serial bits per pixel (unsigned); ≥1.
- dataWidth, 16, width of each output word (signed Qm.n).
- dataFracWidth, 8, fractional bits of output word (documentation only; no arithmetic use).
- pixelShift, 9, left shift applied to the pixel value to form the output word; bitsPerPixel+pixelShift ≤ dataWidth-1 is required (elaboration error otherwise).

Ports:
- serialClock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- serialData  input  1  serial pixel bit.
- serialValid  input  1  serialData is sampled only when high.
- frameStart  input  1  marks the current bit as the first bit of a frame; meaningful only with serialValid.
- frameAck  input  1  consumer accepts the current dataOut frame.
- clearErrors  input  1  synchronous clear of the sticky error flags.
- dataOut  output  numInputs*dataWidth  committed frame; pixel i occupies [dataWidth*i +: dataWidth].
- frameValid  output  1  dataOut holds an unacknowledged frame.
- busy  output  1  high while a frame is being loaded.
- overrunError  output  1  sticky flag: a completed frame was dropped.
- framingError  output  1  sticky flag: frameStart arrived mid-frame.
- parityError  output  1  sticky flag: parity mismatch (optional feature only).

Behaviour:
- Reset values (async, immediate): state IDLE, counters 0, shadow 0, dataOut 0, frameValid 0, busy 0, all error flags 0. Reset mid-load discards the partial frame.
- States:
  - IDLE: bits are ignored unless serialValid&&frameStart.
  - LOAD: accumulating bits.
  - PARITY: optional feature only.
- Transitions:
  - IDLE→LOAD on a serialValid&&frameStart beat. That bit is stored as bit 0 of the frame.
  - In LOAD, each serialValid beat shifts one bit into the shadow register (shift-left) and advances bitCount (0..bitsPerPixel-1). pixelCount (0..numInputs-1) advances on bitCount wrap.
  - The first received pixel ends at index numInputs-1; the last at index 0. Within a pixel, the first bit is the MSB.
- serialValid low: no change, and counters hold. Gaps of any length are allowed.
- frameStart with serialValid while in LOAD: set framingError, restart the frame with this bit as bit 0, and clear the counters. The partial frame is discarded.
- Frame completion is the edge sampling bit bitsPerPixel*numInputs-1.
  - Commit on that same edge when frameValid is 0 or frameAck is 1. dataOut[i] = zero-extended pixel_i << pixelShift. frameValid becomes 1.
  - Otherwise drop the frame, set overrunError, and leave dataOut/frameValid unchanged.
  - Either way, return to IDLE.
- Handshake:
  - frameValid stays high until a cycle with frameAck=1, which clears it at the next edge unless a commit occurs on that same edge (commit wins, frameValid stays 1).
  - frameAck while frameValid=0 is ignored.
  - dataOut is stable while frameValid=1.
- busy = (state != IDLE), registered.
- clearErrors clears all sticky flags at the next edge. An error event on the same edge wins (flag stays 1).
- Example: a 1-bit pixel value 1 with pixelShift=13 yields 16'h2000, the legacy encoding.

Optional Feature:
- Macro: SERIAL_FRAME_LOADER_PARITY_EN.
- Defined:
  - After the last pixel bit, the FSM enters PARITY and the next serialValid beat is an even-parity bit over all frame bits.
  - On a match, commit/overrun rules apply on that edge.
  - On a mismatch, discard the frame, set parityError, and leave dataOut unchanged.
  - frameStart in PARITY is treated as a framing error and restart.
- Undefined: no PARITY state, completion as above, parityError tied 0.

Test Plan:
- numInputs=4, bitsPerPixel=2, pixelShift=4, dataWidth=8. Stream 11 01 00 10 with frameStart on the first bit, contiguous valid -> at the 8th edge frameValid=1, dataOut=32'h3010_0020, busy falls.
- Same frame with serialValid low for 3 cycles between every bit -> identical dataOut; counters hold during gaps.
- Commit frame A, no ack, send frame B -> overrunError=1, dataOut stays A. Then ack plus frame C completing on the ack edge -> dataOut=C, frameValid stays 1.
- frameStart after 5 bits, then a full 8-bit frame -> framingError=1, dataOut reflects only the second frame. clearErrors -> flag 0 next edge.
- Reset asserted after 6 bits of a frame -> all outputs 0 immediately. A subsequent full frame loads correctly.
- With SERIAL_FRAME_LOADER_PARITY_EN: frame 11 01 00 10 plus parity 0 -> commits. Parity 1 -> parityError=1, no commit.
